// File: rtl/multi_roi_color_classifier_if.sv
// Pixel-stream inputs and per-ROI result outputs of multi_roi_color_classifier.
// turn_end is present only when MRCC_TURN_END_EN is defined.
interface multi_roi_color_classifier_if #(
  parameter int NUM_ROI = 2,
  parameter int CNT_W   = 16
);
  logic                     pixel_valid;
  logic                     frame_start;
  logic [9:0]               pixel_x;
  logic [9:0]               pixel_y;
  logic [7:0]               pixel_r8;
  logic [7:0]               pixel_g8;
  logic [7:0]               pixel_b8;
  logic [2*NUM_ROI-1:0]     stable_color;
  logic [NUM_ROI-1:0]       white_flag;
  logic [CNT_W*NUM_ROI-1:0] confidence;
  logic [NUM_ROI-1:0]       result_ready;
  logic                     frame_done;
`ifdef MRCC_TURN_END_EN
  logic [NUM_ROI-1:0]       turn_end;

  modport master (
    output pixel_valid, frame_start, pixel_x, pixel_y, pixel_r8, pixel_g8, pixel_b8,
    input  stable_color, white_flag, confidence, result_ready, frame_done, turn_end
  );
  modport slave (
    input  pixel_valid, frame_start, pixel_x, pixel_y, pixel_r8, pixel_g8, pixel_b8,
    output stable_color, white_flag, confidence, result_ready, frame_done, turn_end
  );
`else
  modport master (
    output pixel_valid, frame_start, pixel_x, pixel_y, pixel_r8, pixel_g8, pixel_b8,
    input  stable_color, white_flag, confidence, result_ready, frame_done
  );
  modport slave (
    input  pixel_valid, frame_start, pixel_x, pixel_y, pixel_r8, pixel_g8, pixel_b8,
    output stable_color, white_flag, confidence, result_ready, frame_done
  );
`endif
endinterface

// File: rtl/multi_roi_color_classifier.sv
// Per-ROI RGB class counting, frame-end dominant-colour pick and vote debouncing.
// Optional MRCC_TURN_END_EN adds turn_end: sustained white clears a stable colour.
module multi_roi_color_classifier #(
  parameter int                    NUM_ROI      = 2,
  parameter logic [NUM_ROI*10-1:0] ROI_X0       = {10'd40, 10'd180},
  parameter logic [NUM_ROI*10-1:0] ROI_X1       = {10'd140, 10'd280},
  parameter logic [NUM_ROI*10-1:0] ROI_Y0       = {10'd60, 10'd60},
  parameter logic [NUM_ROI*10-1:0] ROI_Y1       = {10'd180, 10'd180},
  parameter logic [7:0]            CH_MIN       = 8'd140,
  parameter logic [7:0]            CH_MAX       = 8'd130,
  parameter logic [7:0]            WHITE_MIN    = 8'd160,
  parameter int                    CNT_W        = 16,
  parameter int                    MIN_PIXELS   = 200,
  parameter int                    WHITE_PIXELS = 5000,
  parameter int                    VOTE_FRAMES  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  multi_roi_color_classifier_if.slave   bus
);

  localparam int IDX_W = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROI - 1);
  localparam logic [2:0]       VOTE_C   = 3'(VOTE_FRAMES);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] WHITE_C  = CNT_W'(WHITE_PIXELS);

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_RED   = 2'd1;
  localparam logic [1:0] C_GREEN = 2'd2;
  localparam logic [1:0] C_BLUE  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- stage 1: classify and ROI hit ----------------
  logic is_white, is_red, is_green, is_blue;
  logic [NUM_ROI-1:0] hit_now;

  assign is_white = (bus.pixel_r8 >= WHITE_MIN) && (bus.pixel_g8 >= WHITE_MIN) &&
                    (bus.pixel_b8 >= WHITE_MIN);
  assign is_red   = !is_white && (bus.pixel_r8 >= CH_MIN) &&
                    (bus.pixel_g8 <= CH_MAX) && (bus.pixel_b8 <= CH_MAX);
  assign is_green = !is_white && (bus.pixel_g8 >= CH_MIN) &&
                    (bus.pixel_r8 <= CH_MAX) && (bus.pixel_b8 <= CH_MAX);
  assign is_blue  = !is_white && (bus.pixel_b8 >= CH_MIN) &&
                    (bus.pixel_r8 <= CH_MAX) && (bus.pixel_g8 <= CH_MAX);

  logic               s1_valid_reg;
  logic [3:0]         s1_class_reg;   // {white, blue, green, red}
  logic [NUM_ROI-1:0] s1_hit_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_class_reg <= '0;
      s1_hit_reg   <= '0;
    end else begin
      s1_valid_reg <= bus.pixel_valid;
      s1_class_reg <= {is_white, is_blue, is_green, is_red};
      s1_hit_reg   <= hit_now;
    end
  end

  // ---------------- stage 2: per-ROI saturating class counters ----------------
  logic [4*CNT_W-1:0] snap_bus [NUM_ROI];

  for (genvar gi = 0; gi < NUM_ROI; gi++) begin : g_count
    logic [9:0] x0, x1, y0, y1;
    logic [CNT_W-1:0] cnt_reg  [4];
    logic [CNT_W-1:0] snap_reg [4];

    assign x0 = ROI_X0[gi*10 +: 10];
    assign x1 = ROI_X1[gi*10 +: 10];
    assign y0 = ROI_Y0[gi*10 +: 10];
    assign y1 = ROI_Y1[gi*10 +: 10];
    assign hit_now[gi] = (bus.pixel_x >= x0) && (bus.pixel_x < x1) &&
                         (bus.pixel_y >= y0) && (bus.pixel_y < y1);

    // The pixel sitting in stage 1 during frame_start belongs to the new frame.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < 4; k++) begin
          cnt_reg[k]  <= '0;
          snap_reg[k] <= '0;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (bus.frame_start) begin
            snap_reg[k] <= cnt_reg[k];
            cnt_reg[k]  <= (s1_valid_reg && s1_hit_reg[gi] && s1_class_reg[k]) ?
                           CNT_W'(1) : '0;
          end else if (s1_valid_reg && s1_hit_reg[gi] && s1_class_reg[k] &&
                       (cnt_reg[k] != '1)) begin
            cnt_reg[k] <= cnt_reg[k] + 1'b1;
          end
        end
      end
    end

    assign snap_bus[gi] = {snap_reg[3], snap_reg[2], snap_reg[1], snap_reg[0]};
  end

  // ---------------- evaluation FSM ----------------
  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             first_frame_reg;
  logic             frame_done_reg;
  logic             eval_en;

  // A frame_start during EVAL aborts the current ROI so it is never voted twice.
  assign eval_en = (state_reg == ST_EVAL) && !bus.frame_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      first_frame_reg <= 1'b1;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (bus.frame_start) begin
        if (first_frame_reg) begin
          first_frame_reg <= 1'b0;
        end else begin
          state_reg <= ST_EVAL;
          idx_reg   <= '0;
        end
      end else begin
        case (state_reg)
          ST_EVAL: begin
            if (idx_reg == LAST_IDX) begin
              state_reg      <= ST_DONE;
              frame_done_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.frame_done = frame_done_reg;

  // Dominant class of the ROI under evaluation; strict '>' gives R>G>B on ties.
  logic [4*CNT_W-1:0] cur_snap;
  logic [CNT_W-1:0]   cnt_r, cnt_g, cnt_b, cnt_w, best_cnt, win_cnt;
  logic [1:0]         best_color, raw_color;
  logic               white_now;

  assign cur_snap = snap_bus[idx_reg];

  always_comb begin
    cnt_r      = cur_snap[0*CNT_W +: CNT_W];
    cnt_g      = cur_snap[1*CNT_W +: CNT_W];
    cnt_b      = cur_snap[2*CNT_W +: CNT_W];
    cnt_w      = cur_snap[3*CNT_W +: CNT_W];
    best_cnt   = cnt_r;
    best_color = C_RED;
    if (cnt_g > best_cnt) begin
      best_cnt   = cnt_g;
      best_color = C_GREEN;
    end
    if (cnt_b > best_cnt) begin
      best_cnt   = cnt_b;
      best_color = C_BLUE;
    end
    if (best_cnt < MIN_C) begin
      raw_color = C_NONE;
      win_cnt   = '0;
    end else begin
      raw_color = best_color;
      win_cnt   = best_cnt;
    end
    white_now = (cnt_w >= WHITE_C);
  end

  // ---------------- per-ROI vote and result registers ----------------
  for (genvar gi = 0; gi < NUM_ROI; gi++) begin : g_vote
    logic [1:0]       last_raw_reg;
    logic [2:0]       match_reg;
    logic [2:0]       match_next;
    logic [1:0]       stable_reg;
    logic [CNT_W-1:0] conf_reg;
    logic             white_reg;
    logic             ready_reg;
    logic             sel;
    logic             take_vote;
    logic             fire;

    assign sel        = eval_en && (idx_reg == IDX_W'(gi));
    assign match_next = (raw_color == last_raw_reg) ?
                        ((match_reg >= VOTE_C) ? VOTE_C : match_reg + 3'd1) : 3'd1;
    assign take_vote  = (match_next == VOTE_C) && (raw_color != stable_reg);

`ifdef MRCC_TURN_END_EN
    logic [2:0] white_run_reg;
    logic [2:0] white_run_next;
    logic       turn_end_reg;

    assign white_run_next = white_now ?
                            ((white_run_reg >= VOTE_C) ? VOTE_C : white_run_reg + 3'd1) : 3'd0;
    assign fire = (white_run_next == VOTE_C) && (stable_reg != C_NONE);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        white_run_reg <= '0;
        turn_end_reg  <= 1'b0;
      end else begin
        turn_end_reg <= sel && fire;
        if (sel) white_run_reg <= white_run_next;
      end
    end

    assign bus.turn_end[gi] = turn_end_reg;
`else
    assign fire = 1'b0;
`endif

    // Forced clear on turn end outranks a vote-driven update in the same pass.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        last_raw_reg <= C_NONE;
        match_reg    <= '0;
        stable_reg   <= C_NONE;
        conf_reg     <= '0;
        white_reg    <= 1'b0;
        ready_reg    <= 1'b0;
      end else begin
        ready_reg <= 1'b0;
        if (sel) begin
          last_raw_reg <= raw_color;
          match_reg    <= match_next;
          white_reg    <= white_now;
          if (fire) begin
            stable_reg <= C_NONE;
            conf_reg   <= '0;
          end else if (take_vote) begin
            stable_reg <= raw_color;
            conf_reg   <= win_cnt;
            ready_reg  <= (raw_color != C_NONE);
          end
        end
      end
    end

    assign bus.stable_color[2*gi +: 2]     = stable_reg;
    assign bus.confidence[CNT_W*gi +: CNT_W] = conf_reg;
    assign bus.white_flag[gi]              = white_reg;
    assign bus.result_ready[gi]            = ready_reg;
  end

endmodule

// File: tb/tb_multi_roi_color_classifier.sv
// Directed bench for multi_roi_color_classifier (defaults: ROI0 x 180..279, ROI1 x 40..139).
// Define MRCC_TURN_END_EN to also exercise turn_end.
module tb_multi_roi_color_classifier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_roi_color_classifier_if #(.NUM_ROI(2), .CNT_W(16)) bus ();

  multi_roi_color_classifier #(.NUM_ROI(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [1:0] rr_log [0:7];
  logic       fd_log [0:7];
  logic [1:0] te_log [0:7];

  task automatic drive_idle();
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.pixel_x     = '0;
    bus.pixel_y     = '0;
    bus.pixel_r8    = '0;
    bus.pixel_g8    = '0;
    bus.pixel_b8    = '0;
  endtask

  task automatic send_pixels(input int n, input logic [9:0] x, input logic [9:0] y,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pixel_valid = 1'b1;
      bus.pixel_x = x;  bus.pixel_y = y;
      bus.pixel_r8 = r; bus.pixel_g8 = g; bus.pixel_b8 = b;
    end
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    @(negedge clk);
  endtask

  // frame_start is cycle 0; log slot k holds the outputs seen in cycle k.
  task automatic pulse_fs();
    @(negedge clk);
    bus.frame_start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rr_log[k] = '0; fd_log[k] = 1'b0; te_log[k] = '0;
    end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.frame_start = 1'b0;
      rr_log[k] = bus.result_ready;
      fd_log[k] = bus.frame_done;
`ifdef MRCC_TURN_END_EN
      te_log[k] = bus.turn_end;
`endif
    end
    $display("frame_start: stable=%b conf0=%0d conf1=%0d white=%b",
             bus.stable_color, bus.confidence[15:0], bus.confidence[31:16], bus.white_flag);
  endtask

  task automatic test_reset();
    int n;
    drive_idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.stable_color !== 4'b0000) begin miscompares++; $display("FAIL reset_stable: got %b expected 0000", bus.stable_color); end
    vectors++;
    if (bus.confidence !== 32'd0) begin miscompares++; $display("FAIL reset_conf: got %h expected 0", bus.confidence); end
    vectors++;
    if ({bus.result_ready, bus.white_flag, bus.frame_done} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000", {bus.result_ready, bus.white_flag, bus.frame_done});
    end
    reset = 1'b1;
    @(negedge clk);
    pulse_fs();
    n = 0;
    for (int k = 1; k < 8; k++) n += int'(fd_log[k]) + int'(rr_log[k] != 2'b00);
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL first_frame_quiet: got %0d pulses expected 0", n); end
    vectors++;
    if (bus.stable_color !== 4'b0000) begin miscompares++; $display("FAIL first_frame_stable: got %b expected 0000", bus.stable_color); end
  endtask

  task automatic test_red_roi0();
    int n;
    for (int f = 1; f <= 3; f++) begin
      send_pixels(300, 10'd279, 10'd179, 8'd255, 8'd0, 8'd0);  // last inside corner of ROI0
      send_pixels(40, 10'd280, 10'd100, 8'd255, 8'd0, 8'd0);   // x == x1, outside
      send_pixels(40, 10'd200, 10'd180, 8'd255, 8'd0, 8'd0);   // y == y1, outside
      send_pixels(60, 10'd200, 10'd100, 8'd200, 8'd131, 8'd0); // g above CH_MAX: no class
      pulse_fs();
      n = 0;
      for (int k = 1; k < 8; k++) n += int'(rr_log[k][0]);
      vectors++;
      if (n !== ((f == 3) ? 1 : 0)) begin miscompares++; $display("FAIL red_pulse_count f%0d: got %0d expected %0d", f, n, (f == 3) ? 1 : 0); end
      vectors++;
      if (fd_log[3] !== 1'b1) begin miscompares++; $display("FAIL red_frame_done f%0d: got %b expected 1", f, fd_log[3]); end
    end
    vectors++;
    if (rr_log[2] !== 2'b01) begin miscompares++; $display("FAIL red_pulse_cycle2: got %b expected 01", rr_log[2]); end
    vectors++;
    if (bus.stable_color !== 4'b0001) begin miscompares++; $display("FAIL red_stable: got %b expected 0001", bus.stable_color); end
    vectors++;
    if (bus.confidence !== {16'd0, 16'd300}) begin miscompares++; $display("FAIL red_conf: got %h expected 0000012c", bus.confidence); end
  endtask

  task automatic test_tie_and_none_roi1();
    int n0, n1;
    for (int f = 1; f <= 3; f++) begin
      send_pixels(250, 10'd40, 10'd60, 8'd0, 8'd255, 8'd0);
      send_pixels(250, 10'd139, 10'd60, 8'd0, 8'd0, 8'd255);
      pulse_fs();
    end
    n0 = 0; n1 = 0;
    for (int k = 1; k < 8; k++) begin n0 += int'(rr_log[k][0]); n1 += int'(rr_log[k][1]); end
    vectors++;
    if (bus.stable_color !== 4'b1000) begin miscompares++; $display("FAIL tie_stable: got %b expected 1000", bus.stable_color); end
    vectors++;
    if (bus.confidence !== {16'd250, 16'd0}) begin miscompares++; $display("FAIL tie_conf: got %h expected 00fa0000", bus.confidence); end
    vectors++;
    if (rr_log[3] !== 2'b10 || n1 !== 1 || n0 !== 0) begin
      miscompares++; $display("FAIL tie_pulse: got cycle3=%b n1=%0d n0=%0d expected 10/1/0", rr_log[3], n1, n0);
    end
    for (int f = 1; f <= 3; f++) begin
      send_pixels(150, 10'd100, 10'd100, 8'd0, 8'd0, 8'd255);
      pulse_fs();
      n1 = 0;
      for (int k = 1; k < 8; k++) n1 += int'(rr_log[k] != 2'b00);
      vectors++;
      if (n1 !== 0) begin miscompares++; $display("FAIL none_no_pulse f%0d: got %0d expected 0", f, n1); end
      vectors++;
      if (bus.stable_color !== ((f == 3) ? 4'b0000 : 4'b1000)) begin
        miscompares++; $display("FAIL none_stable f%0d: got %b expected %b", f, bus.stable_color, (f == 3) ? 4'b0000 : 4'b1000);
      end
    end
    vectors++;
    if (bus.confidence !== 32'd0) begin miscompares++; $display("FAIL none_conf: got %h expected 0", bus.confidence); end
  endtask

  task automatic test_saturation();
    send_pixels(300, 10'd180, 10'd60, 8'd255, 8'd0, 8'd0);
    pulse_fs();
    send_pixels(300, 10'd180, 10'd60, 8'd255, 8'd0, 8'd0);
    pulse_fs();
    vectors++;
    if (bus.stable_color !== 4'b0000) begin miscompares++; $display("FAIL sat_pre_stable: got %b expected 0000", bus.stable_color); end
    send_pixels(70000, 10'd180, 10'd60, 8'd255, 8'd0, 8'd0);
    pulse_fs();
    vectors++;
    if (bus.stable_color !== 4'b0001) begin miscompares++; $display("FAIL sat_stable: got %b expected 0001", bus.stable_color); end
    vectors++;
    if (bus.confidence[15:0] !== 16'd65535) begin miscompares++; $display("FAIL sat_conf: got %0d expected 65535", bus.confidence[15:0]); end
    vectors++;
    if (rr_log[2] !== 2'b01) begin miscompares++; $display("FAIL sat_pulse: got %b expected 01", rr_log[2]); end
  endtask

`ifdef MRCC_TURN_END_EN
  task automatic test_turn_end();
    int n;
    for (int f = 1; f <= 3; f++) begin
      send_pixels(6000, 10'd200, 10'd100, 8'd255, 8'd255, 8'd255);
      pulse_fs();
      vectors++;
      if (bus.white_flag[0] !== 1'b1) begin miscompares++; $display("FAIL te_white f%0d: got %b expected 1", f, bus.white_flag[0]); end
      n = 0;
      for (int k = 1; k < 8; k++) n += int'(te_log[k][0]);
      vectors++;
      if (n !== ((f == 3) ? 1 : 0)) begin miscompares++; $display("FAIL te_count f%0d: got %0d expected %0d", f, n, (f == 3) ? 1 : 0); end
    end
    vectors++;
    if (te_log[2] !== 2'b01) begin miscompares++; $display("FAIL te_cycle2: got %b expected 01", te_log[2]); end
    vectors++;
    if (bus.stable_color !== 4'b0000 || bus.confidence !== 32'd0) begin
      miscompares++; $display("FAIL te_cleared: got %b/%h expected 0000/0", bus.stable_color, bus.confidence);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic fd_b [0:9];
    int n;
    @(negedge clk);
    bus.frame_start = 1'b1;
    fd_b[0] = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) bus.frame_start = 1'b0;
      fd_b[k] = bus.frame_done;
    end
    n = 0;
    for (int k = 1; k < 10; k++) n += int'(fd_b[k]);
    $display("back_to_back: frame_done count=%0d at cycle4=%b", n, fd_b[4]);
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL b2b_count: got %0d expected 1", n); end
    vectors++;
    if (fd_b[4] !== 1'b1) begin miscompares++; $display("FAIL b2b_cycle4: got %b expected 1", fd_b[4]); end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp_sc;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_sc = 2'b00;
    vectors++;
    if (bus.stable_color[1:0] !== exp_sc || bus.confidence !== 32'd0) begin
      miscompares++; $display("FAIL async_reset: got %b/%h expected 00/0", bus.stable_color[1:0], bus.confidence);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("async_reset: stable=%b conf=%h", bus.stable_color, bus.confidence);
  endtask

  initial begin
    test_reset();
    test_red_roi0();
    test_tie_and_none_roi1();
    test_saturation();
`ifdef MRCC_TURN_END_EN
    test_turn_end();
`endif
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_roi_color_classifier.md
Name: multi_roi_color_classifier

Overview:
- Parametrised successor to the single-ROI colour detector.
- Classifies the RGB888 pixel stream from the frame-buffer reader into RED/GREEN/BLUE/WHITE over NUM_ROI independent rectangular ROIs.
- Per ROI: counts class pixels each frame, picks a dominant colour at frame end, and debounces it over VOTE_FRAMES consecutive frames.
- Feeds per-ROI stable colours, confidences and pulses to the game FSM and overlay; sits on sys_clk between the image reader and the result consumers.

Parameters:
- NUM_ROI, 2, number of ROIs (1..4).
- ROI_X0, {10'd40,10'd180}, packed NUM_ROI*10 X starts (inclusive), ROI 0 in LSBs.
- ROI_X1, {10'd140,10'd280}, packed X ends (exclusive).
- ROI_Y0, {10'd60,10'd60}, packed Y starts (inclusive).
- ROI_Y1, {10'd180,10'd180}, packed Y ends (exclusive).
- CH_MIN, 8'd140, minimum level of the dominant channel.
- CH_MAX, 8'd130, maximum level of each non-dominant channel.
- WHITE_MIN, 8'd160, all channels must be at or above this for WHITE.
- CNT_W, 16, counter width.
- MIN_PIXELS, 200, minimum count for an R/G/B result.
- WHITE_PIXELS, 5000, white count at or above which white_flag is set.
- VOTE_FRAMES, 3, consecutive identical raw results required to update the stable result (1..7).

Ports:
- clk  in  1  sys_clk pixel clock
- reset  in  1  asynchronous, active-low reset
- pixel_valid  in  1  pixel qualifier
- frame_start  in  1  one-cycle pulse at start of frame
- pixel_x  in  10  pixel column
- pixel_y  in  10  pixel row
- pixel_r8  in  8  red
- pixel_g8  in  8  green
- pixel_b8  in  8  blue
- stable_color  out  2*NUM_ROI  per ROI: 00 NONE, 01 RED, 10 GREEN, 11 BLUE
- white_flag  out  NUM_ROI  per ROI: last evaluated white count ≥ WHITE_PIXELS
- confidence  out  CNT_W*NUM_ROI  winning-class count of the last stable update
- result_ready  out  NUM_ROI  one-cycle pulse when stable_color changes to a non-NONE value
- frame_done  out  1  one-cycle pulse after all ROIs are evaluated

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, FSM IDLE, first_frame=1.
- Stage 1, registered: classify the pixel and compute ROI hits, one cycle of latency.
  - RED: r≥CH_MIN, g≤CH_MAX, b≤CH_MAX. GREEN and BLUE are analogous.
  - WHITE: all three channels ≥ WHITE_MIN. WHITE takes precedence over colours; the classes are mutually exclusive.
  - ROI hit: x0≤x<x1 and y0≤y<y1. Overlapping ROIs each count the pixel.
- Stage 2: per ROI there are four CNT_W counters. Each increments on a registered valid, hit and class, and saturates at all-ones (no wrap).
- On frame_start:
  - All counters are copied to snapshot registers, then cleared in the same edge.
  - A stage-1 pixel in flight in that cycle is counted into the new frame.
  - If first_frame=1: clear first_frame and do not evaluate.
  - Otherwise the FSM enters EVAL with idx=0.
- FSM IDLE → EVAL → DONE → IDLE.
  - EVAL: one ROI per cycle, idx 0..NUM_ROI-1.
  - raw = class with the largest snapshot count, tie priority R>G>B; raw=NONE if that count < MIN_PIXELS.
  - white_flag[idx] is updated.
  - Vote: if raw == last_raw[idx], match_cnt[idx] increments, saturating at VOTE_FRAMES. Otherwise last_raw=raw and match_cnt=1.
  - When match_cnt reaches VOTE_FRAMES and raw ≠ stable_color[idx]: stable_color ← raw, confidence ← winning count (0 for NONE).
  - result_ready[idx] pulses the cycle after EVAL(idx) if the new stable value is non-NONE.
  - DONE: frame_done=1 for one cycle.
- Latency from frame_start: result_ready[i] at cycle i+2; frame_done at cycle NUM_ROI+1.
- If frame_start arrives during EVAL or DONE:
  - Take a new snapshot and restart EVAL at idx=0.
  - ROIs not yet evaluated keep their previous outputs.
  - No frame_done is emitted for the aborted pass.
- An unchanged stable colour gives no pulse. A transition to NONE updates stable_color with no pulse.

Optional Feature:
- Macro MRCC_TURN_END_EN.
- When defined, adds output port turn_end (NUM_ROI).
- turn_end[i] pulses, at the same cycle position as result_ready[i], when white_flag[i] has been set for VOTE_FRAMES consecutive evaluations while stable_color[i] ≠ NONE. stable_color[i] is then forced to NONE, with confidence 0.
- When undefined, the port and its logic are absent, and white_flag only reports.

Test Plan:
- Reset with outputs checked, then one frame_start → no evaluation: frame_done stays 0 and all outputs stay 0.
- ROI0 gets 300 pure-red pixels (255,0,0) per frame for 3 evaluated frames:
  - stable_color[1:0]=01, confidence=300, single result_ready[0] pulse on the 3rd frame.
  - ROI1 remains 00.
- ROI1 gets 250 green and 250 blue pixels for 3 frames → tie resolves GREEN (10). Then 150 blue per frame → raw NONE, stable becomes 00 after 3 frames with no pulse.
- 70000 red pixels in ROI0 with CNT_W=16 → count saturates at 65535, and confidence=65535 after the vote.
- Second frame_start 1 cycle after the first (NUM_ROI=2) → no frame_done for the first pass; exactly one frame_done 3 cycles after the second.
- With MRCC_TURN_END_EN: stable RED, then 6000 white pixels in ROI0 for 3 frames → turn_end[0] pulse and stable_color=00.
